// File: rtl/rd_buf_ctrl_if.sv
// Read-buffer fill bus: DDR read command/data channel plus the 128-bit
// buffer write port. The controller is the master side.
interface rd_buf_ctrl_if #(
    parameter int unsigned ADDR_W = 28
);
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic [7:0]        rd_cmd_len;
    logic              rd_data_valid;
    logic [127:0]      rd_data;
    logic              buf_wr_en;
    logic [9:0]        buf_wr_addr;
    logic [127:0]      buf_wr_data;

    modport master (
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        input  rd_cmd_ready,
        input  rd_data_valid, rd_data,
        output buf_wr_en, buf_wr_addr, buf_wr_data
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        output rd_cmd_ready,
        output rd_data_valid, rd_data,
        input  buf_wr_en, buf_wr_addr, buf_wr_data
    );
endinterface

// File: rtl/rd_buf_ctrl.sv
// Ping-pong line sequencer for the frame read buffer: issues DDR read bursts
// line by line from the frame base and writes returned beats into the free
// 512-word bank, flagging each completed bank to the display side.
module rd_buf_ctrl #(
    parameter int unsigned H_WORDS     = 480,
    parameter int unsigned V_LINES     = 1080,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned LINE_STRIDE = 7680,
    parameter int unsigned ADDR_W      = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              frame_start,
    input  logic [1:0]        line_free,
    output logic [1:0]        line_ready,
    output logic              frame_done,
    output logic              err,
    rd_buf_ctrl_if.master     bus
);

    localparam int unsigned LINE_W = $clog2(V_LINES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        CMD,
        DATA,
        DRAIN
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [LINE_W-1:0]   line_cnt_q,  line_cnt_d;
    logic                fill_bank_q, fill_bank_d;
    logic [9:0]          word_idx_q,  word_idx_d;
    logic [8:0]          beat_cnt_q,  beat_cnt_d;
    logic                rdy_pend_q,  rdy_pend_d;
    logic                rdy_bank_q,  rdy_bank_d;
    logic                done_pend_q, done_pend_d;
    logic [1:0]          line_ready_q, line_ready_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q,       err_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
    logic [7:0]          cmd_len_q,   cmd_len_d;
    logic                wr_en_q,     wr_en_d;
    logic [9:0]          wr_addr_q,   wr_addr_d;
    logic [127:0]        wr_data_q,   wr_data_d;

    logic [8:0]          beats_left;
    logic [9:0]          word_nxt;
    logic [LINE_W-1:0]   line_nxt;

    // Beats-minus-one for a burst starting at word w: min(BURST_LEN, H_WORDS-w) - 1.
    function automatic logic [7:0] burst_len(input logic [9:0] w);
        logic [9:0] rem;
        rem = 10'(H_WORDS) - w;
        if (rem > 10'(BURST_LEN)) begin
            rem = 10'(BURST_LEN);
        end
        return 8'(rem - 10'd1);
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            line_cnt_q   <= '0;
            fill_bank_q  <= 1'b0;
            word_idx_q   <= '0;
            beat_cnt_q   <= '0;
            rdy_pend_q   <= 1'b0;
            rdy_bank_q   <= 1'b0;
            done_pend_q  <= 1'b0;
            line_ready_q <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            line_cnt_q   <= line_cnt_d;
            fill_bank_q  <= fill_bank_d;
            word_idx_q   <= word_idx_d;
            beat_cnt_q   <= beat_cnt_d;
            rdy_pend_q   <= rdy_pend_d;
            rdy_bank_q   <= rdy_bank_d;
            done_pend_q  <= done_pend_d;
            line_ready_q <= line_ready_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Next-state, command generation, buffer writes and bank bookkeeping.
    // A finished line is recorded in rdy_pend/done_pend first so that
    // line_ready and frame_done rise one cycle after the final buffer write.
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        line_cnt_d   = line_cnt_q;
        fill_bank_d  = fill_bank_q;
        word_idx_d   = word_idx_q;
        beat_cnt_d   = beat_cnt_q;
        rdy_pend_d   = 1'b0;
        rdy_bank_d   = rdy_bank_q;
        done_pend_d  = 1'b0;
        frame_done_d = done_pend_q;
        err_d        = err_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_len_d    = cmd_len_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        line_ready_d = line_ready_q & ~line_free;
        if (rdy_pend_q) begin
            line_ready_d[rdy_bank_q] = 1'b1;
        end

        beats_left = beat_cnt_q - {8'd0, bus.rd_data_valid};
        word_nxt   = word_idx_q + 10'd1;
        line_nxt   = line_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = WAIT_BANK;
                end
            end
            WAIT_BANK: begin
                if (!frame_start && !line_ready_q[fill_bank_q]) begin
                    word_idx_d  = '0;
                    cmd_valid_d = 1'b1;
                    cmd_addr_d  = line_addr_q;
                    cmd_len_d   = burst_len(10'd0);
                    state_d     = CMD;
                end
            end
            CMD: begin
                if (bus.rd_cmd_ready) begin
                    // An accepted command always returns its beats, so a
                    // restart on the handshake cycle must still drain them.
                    cmd_valid_d = 1'b0;
                    beat_cnt_d  = {1'b0, cmd_len_q} + 9'd1;
                    state_d     = frame_start ? DRAIN : DATA;
                end else if (frame_start) begin
                    state_d = WAIT_BANK;
                end
            end
            DATA: begin
                if (frame_start) begin
                    beat_cnt_d = beats_left;
                    state_d    = (beats_left == '0) ? WAIT_BANK : DRAIN;
                end else if (bus.rd_data_valid) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = {fill_bank_q, word_idx_q[8:0]};
                    wr_data_d  = bus.rd_data;
                    word_idx_d = word_nxt;
                    beat_cnt_d = beats_left;
                    if (beats_left == '0) begin
                        if (word_nxt < 10'(H_WORDS)) begin
                            cmd_valid_d = 1'b1;
                            cmd_addr_d  = line_addr_q + ADDR_W'({word_nxt, 4'b0000});
                            cmd_len_d   = burst_len(word_nxt);
                            state_d     = CMD;
                        end else begin
                            rdy_pend_d  = 1'b1;
                            rdy_bank_d  = fill_bank_q;
                            fill_bank_d = ~fill_bank_q;
                            line_cnt_d  = line_nxt;
                            line_addr_d = line_addr_q + ADDR_W'(LINE_STRIDE);
                            if (line_nxt == LINE_W'(V_LINES)) begin
                                done_pend_d = 1'b1;
                                state_d     = IDLE;
                            end else begin
                                state_d = WAIT_BANK;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                beat_cnt_d = beats_left;
                if (beats_left == '0) begin
                    state_d = WAIT_BANK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.rd_data_valid && (state_q inside {IDLE, WAIT_BANK, CMD})) begin
            err_d = 1'b1;
        end

        // Restart overrides line_free and any pending bank completion.
        if (frame_start) begin
            line_addr_d  = frame_base;
            line_cnt_d   = '0;
            fill_bank_d  = 1'b0;
            word_idx_d   = '0;
            line_ready_d = '0;
            rdy_pend_d   = 1'b0;
            cmd_valid_d  = 1'b0;
        end
    end

    assign bus.rd_cmd_valid = cmd_valid_q;
    assign bus.rd_cmd_addr  = cmd_addr_q;
    assign bus.rd_cmd_len   = cmd_len_q;
    assign bus.buf_wr_en    = wr_en_q;
    assign bus.buf_wr_addr  = wr_addr_q;
    assign bus.buf_wr_data  = wr_data_q;
    assign line_ready       = line_ready_q;
    assign frame_done       = frame_done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_rd_buf_ctrl.sv
// Directed bench for rd_buf_ctrl: two instances (480-word and 40-word lines)
// share stimulus; sel chooses which instance's outputs are compared.
module tb_rd_buf_ctrl;

    localparam int unsigned AW = 28;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] frame_base;
    logic          frame_start;
    logic [1:0]    line_free;
    logic          cmd_ready;
    logic          data_valid;
    logic [127:0]  data;
    logic          sel;

    logic [1:0]    a_line_ready, b_line_ready;
    logic          a_frame_done, b_frame_done;
    logic          a_err, b_err;

    logic          obs_cmd_valid;
    logic [AW-1:0] obs_cmd_addr;
    logic [7:0]    obs_cmd_len;
    logic          obs_wr_en;
    logic [9:0]    obs_wr_addr;
    logic [127:0]  obs_wr_data;
    logic [1:0]    obs_line_ready;
    logic          obs_frame_done;
    logic          obs_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rd_buf_ctrl_if #(.ADDR_W(AW)) a_if ();
    rd_buf_ctrl_if #(.ADDR_W(AW)) b_if ();

    assign a_if.rd_cmd_ready  = cmd_ready;
    assign a_if.rd_data_valid = data_valid;
    assign a_if.rd_data       = data;
    assign b_if.rd_cmd_ready  = cmd_ready;
    assign b_if.rd_data_valid = data_valid;
    assign b_if.rd_data       = data;

    rd_buf_ctrl #(.H_WORDS(480), .V_LINES(1080), .BURST_LEN(16),
                  .LINE_STRIDE(7680), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_base(frame_base),
        .frame_start(frame_start), .line_free(line_free),
        .line_ready(a_line_ready), .frame_done(a_frame_done),
        .err(a_err), .bus(a_if.master));

    rd_buf_ctrl #(.H_WORDS(40), .V_LINES(3), .BURST_LEN(16),
                  .LINE_STRIDE(7680), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_base(frame_base),
        .frame_start(frame_start), .line_free(line_free),
        .line_ready(b_line_ready), .frame_done(b_frame_done),
        .err(b_err), .bus(b_if.master));

    assign obs_cmd_valid  = sel ? b_if.rd_cmd_valid : a_if.rd_cmd_valid;
    assign obs_cmd_addr   = sel ? b_if.rd_cmd_addr  : a_if.rd_cmd_addr;
    assign obs_cmd_len    = sel ? b_if.rd_cmd_len   : a_if.rd_cmd_len;
    assign obs_wr_en      = sel ? b_if.buf_wr_en    : a_if.buf_wr_en;
    assign obs_wr_addr    = sel ? b_if.buf_wr_addr  : a_if.buf_wr_addr;
    assign obs_wr_data    = sel ? b_if.buf_wr_data  : a_if.buf_wr_data;
    assign obs_line_ready = sel ? b_line_ready      : a_line_ready;
    assign obs_frame_done = sel ? b_frame_done      : a_frame_done;
    assign obs_err        = sel ? b_err             : a_err;

    function automatic logic [127:0] mkdata(input int unsigned w, input int unsigned bank);
        return {32'hDA7A_0000 + 32'(w), 32'(bank), ~32'(w), 32'h5A5A_0000 ^ 32'(w * 3)};
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_base  = '0;
        line_free   = '0;
        cmd_ready   = 1'b0;
        data_valid  = 1'b0;
        data        = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulses frame_start; optionally checks the two-cycle start latency.
    task automatic start_frame(input logic [AW-1:0] base, input bit chk);
        frame_start = 1'b1;
        frame_base  = base;
        @(negedge clk);
        frame_start = 1'b0;
        if (chk) begin
            compared++;
            if (obs_cmd_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL start_lat1: rd_cmd_valid=%b want 0", obs_cmd_valid);
            end
            @(negedge clk);
            compared++;
            if (obs_cmd_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL start_lat2: rd_cmd_valid=%b want 1", obs_cmd_valid);
            end
        end
    endtask

    task automatic expect_cmd(input logic [AW-1:0] addr, input logic [7:0] len);
        int unsigned n;
        n = 0;
        while (obs_cmd_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (obs_cmd_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL cmd_timeout: rd_cmd_valid=%b want 1 (addr %0h)", obs_cmd_valid, addr);
        end
        compared++;
        if (obs_cmd_addr !== addr) begin
            mismatched++;
            $display("FAIL cmd_addr: got %0h want %0h", obs_cmd_addr, addr);
        end
        compared++;
        if (obs_cmd_len !== len) begin
            mismatched++;
            $display("FAIL cmd_len: got %0d want %0d", obs_cmd_len, len);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        compared++;
        if (obs_cmd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL cmd_drop: rd_cmd_valid=%b want 0", obs_cmd_valid);
        end
    endtask

    task automatic burst(input int unsigned n, input int unsigned w0, input int unsigned bank);
        for (int unsigned j = 0; j < n; j++) begin
            data_valid = 1'b1;
            data       = mkdata(w0 + j, bank);
            @(negedge clk);
            compared++;
            if (obs_wr_en !== 1'b1) begin
                mismatched++;
                $display("FAIL wr_en: got %b want 1 (word %0d)", obs_wr_en, w0 + j);
            end
            compared++;
            if (obs_wr_addr !== 10'(bank * 512 + w0 + j)) begin
                mismatched++;
                $display("FAIL wr_addr: got %0d want %0d", obs_wr_addr, bank * 512 + w0 + j);
            end
            compared++;
            if (obs_wr_data !== mkdata(w0 + j, bank)) begin
                mismatched++;
                $display("FAIL wr_data: got %h want %h", obs_wr_data, mkdata(w0 + j, bank));
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic run_line(input logic [AW-1:0] base, input int unsigned h, input int unsigned bank);
        int unsigned n;
        for (int unsigned off = 0; off < h; off += 16) begin
            n = (h - off < 16) ? h - off : 16;
            expect_cmd(base + AW'(off * 16), 8'(n - 1));
            burst(n, off, bank);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            compared++;
            if ({obs_cmd_valid, obs_wr_en, obs_line_ready, obs_frame_done, obs_err} !== 6'b0) begin
                mismatched++;
                $display("FAIL reset_flags[%0d]: got %b want 000000", s,
                         {obs_cmd_valid, obs_wr_en, obs_line_ready, obs_frame_done, obs_err});
            end
            compared++;
            if (obs_cmd_addr !== '0 || obs_cmd_len !== '0) begin
                mismatched++;
                $display("FAIL reset_cmd[%0d]: addr %0h len %0d want 0 0", s, obs_cmd_addr, obs_cmd_len);
            end
            compared++;
            if (obs_wr_addr !== '0 || obs_wr_data !== '0) begin
                mismatched++;
                $display("FAIL reset_wr[%0d]: addr %0h data %h want 0 0", s, obs_wr_addr, obs_wr_data);
            end
        end
    endtask

    task automatic test_full_line();
        sel = 1'b0;
        start_frame(28'h010_0000, 1'b1);
        run_line(28'h010_0000, 480, 0);
        compared++;
        if (obs_line_ready !== 2'b00) begin
            mismatched++;
            $display("FAIL line0_rdy_early: got %b want 00", obs_line_ready);
        end
        @(negedge clk);
        compared++;
        if (obs_line_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL line0_rdy: got %b want 01", obs_line_ready);
        end
    endtask

    // Continues from test_full_line: line 1 is in flight into bank 1.
    task automatic test_mid_frame_restart();
        sel = 1'b0;
        expect_cmd(28'h010_1E00, 8'd15);
        burst(5, 0, 1);
        frame_start = 1'b1;
        frame_base  = 28'h040_0000;
        @(negedge clk);
        frame_start = 1'b0;
        compared++;
        if (obs_line_ready !== 2'b00) begin
            mismatched++;
            $display("FAIL restart_rdy: got %b want 00", obs_line_ready);
        end
        for (int unsigned j = 0; j < 11; j++) begin
            data_valid = 1'b1;
            data       = mkdata(j + 5, 1);
            @(negedge clk);
            compared++;
            if (obs_wr_en !== 1'b0 || obs_cmd_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL drain_beat%0d: wr_en %b cmd_valid %b want 0 0", j, obs_wr_en, obs_cmd_valid);
            end
        end
        data_valid = 1'b0;
        expect_cmd(28'h040_0000, 8'd15);
        compared++;
        if (obs_err !== 1'b0 || obs_line_ready !== 2'b00) begin
            mismatched++;
            $display("FAIL restart_state: err %b line_ready %b want 0 00", obs_err, obs_line_ready);
        end
    endtask

    task automatic test_partial_burst();
        do_reset();
        sel = 1'b1;
        start_frame(28'h020_0000, 1'b1);
        run_line(28'h020_0000, 40, 0);
        compared++;
        if (obs_wr_addr !== 10'd39) begin
            mismatched++;
            $display("FAIL last_wr_addr: got %0d want 39", obs_wr_addr);
        end
        @(negedge clk);
        compared++;
        if (obs_line_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL partial_rdy: got %b want 01", obs_line_ready);
        end
    endtask

    task automatic test_ping_pong();
        int unsigned pulses;
        do_reset();
        sel = 1'b1;
        start_frame(28'h030_0000, 1'b1);
        run_line(28'h030_0000, 40, 0);
        run_line(28'h030_1E00, 40, 1);
        @(negedge clk);
        compared++;
        if (obs_line_ready !== 2'b11) begin
            mismatched++;
            $display("FAIL pp_both_rdy: got %b want 11", obs_line_ready);
        end
        repeat (10) @(negedge clk);
        compared++;
        if (obs_cmd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL pp_stall: rd_cmd_valid=%b want 0", obs_cmd_valid);
        end
        line_free = 2'b01;
        @(negedge clk);
        line_free = 2'b00;
        compared++;
        if (obs_line_ready !== 2'b10 || obs_cmd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL pp_free: line_ready %b cmd_valid %b want 10 0", obs_line_ready, obs_cmd_valid);
        end
        @(negedge clk);
        compared++;
        if (obs_cmd_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL pp_resume: rd_cmd_valid=%b want 1", obs_cmd_valid);
        end
        line_free = 2'b01;
        @(negedge clk);
        line_free = 2'b00;
        compared++;
        if (obs_line_ready !== 2'b10) begin
            mismatched++;
            $display("FAIL pp_free_clear_bank: got %b want 10", obs_line_ready);
        end
        run_line(28'h030_3C00, 40, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (obs_frame_done === 1'b1) pulses++;
            @(negedge clk);
        end
        compared++;
        if (pulses != 1) begin
            mismatched++;
            $display("FAIL frame_done_pulses: got %0d want 1", pulses);
        end
        compared++;
        if (obs_line_ready !== 2'b11 || obs_cmd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL pp_end: line_ready %b cmd_valid %b want 11 0", obs_line_ready, obs_cmd_valid);
        end
    endtask

    task automatic test_cmd_stall();
        int unsigned hs;
        do_reset();
        sel = 1'b0;
        start_frame(28'h0AB_C000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            compared++;
            if ({obs_cmd_valid, obs_cmd_addr, obs_cmd_len} !== {1'b1, 28'h0AB_C000, 8'd15}) begin
                mismatched++;
                $display("FAIL stall_hold%0d: valid %b addr %0h len %0d want 1 abc000 15",
                         i, obs_cmd_valid, obs_cmd_addr, obs_cmd_len);
            end
            @(negedge clk);
        end
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_ready = 1'b1;
            if (obs_cmd_valid === 1'b1) hs++;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        compared++;
        if (hs != 1) begin
            mismatched++;
            $display("FAIL stall_accepts: got %0d want 1", hs);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (obs_cmd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_outstanding: rd_cmd_valid=%b want 0", obs_cmd_valid);
        end
    endtask

    task automatic test_err();
        do_reset();
        sel = 1'b0;
        data_valid = 1'b1;
        data       = '1;
        @(negedge clk);
        data_valid = 1'b0;
        compared++;
        if (obs_err !== 1'b1 || obs_wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL err_set: err %b wr_en %b want 1 0", obs_err, obs_wr_en);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (obs_err !== 1'b1) begin
            mismatched++;
            $display("FAIL err_sticky: got %b want 1", obs_err);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (obs_err !== 1'b0) begin
            mismatched++;
            $display("FAIL err_reset: got %b want 0", obs_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_full_line();
        test_mid_frame_restart();
        test_partial_burst();
        test_ping_pong();
        test_cmd_stall();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", compared);
        $fatal(1, "timeout");
    end

endmodule
